// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: 2-flop sync, per-channel stability counter, and registered
// press/release/long-press pulses.
module key_debounce_multi #(
  parameter int unsigned N_KEYS       = 4,
  parameter int unsigned DEBOUNCE_CNT = 500000,
  parameter int unsigned LONG_CNT     = 50000000,
  parameter int unsigned CNT_W        = 26,
  parameter bit          ACTIVE_LEVEL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  localparam logic [N_KEYS-1:0] INACTIVE = {N_KEYS{~ACTIVE_LEVEL}};
  localparam logic [CNT_W-1:0]  DB_MAX   = CNT_W'(DEBOUNCE_CNT - 1);

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= INACTIVE;
      sync2_q <= INACTIVE;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  // Normalise so that 1 always means pressed internally.
  assign raw = sync2_q ^ INACTIVE;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_comb begin
      db_cnt_d  = db_cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (raw[i] == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_MAX) begin
        db_cnt_d  = '0;
        level_d   = raw[i];
        press_d   = raw[i];
        release_d = ~raw[i];
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;

    if (LONG_CNT > 0) begin : g_long
      localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CNT - 1);
      localparam logic [CNT_W-1:0] LONG_SAT = CNT_W'(LONG_CNT);

      logic [CNT_W-1:0] hold_q, hold_d;
      logic             long_q, long_d;

      // A release commit clears the count first, so key_long can never coincide with it.
      always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d || release_d || !level_q) begin
          hold_d = '0;
        end else if (hold_q == LONG_MAX) begin
          hold_d = LONG_SAT;
          long_d = 1'b1;
        end else if (hold_q < LONG_MAX) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_q <= '0;
          long_q <= 1'b0;
        end else begin
          hold_q <= hold_d;
          long_q <= long_d;
        end
      end

      assign key_long[i] = long_q;
    end else begin : g_no_long
      assign key_long[i] = 1'b0;
    end
  end

endmodule
